// File: rtl/complete.sv
`timescale 1ns / 1ps
// complete: session-layer test top. Two call endpoints (ONE, TWO) turn 4-bit user commands
// into call-state transitions and talk over an internal fixed-latency two-way message link.
// Endpoint 0 is ONE, endpoint 1 is TWO; link_q[e] carries the messages sent by endpoint e.

module complete #(
    parameter int unsigned LINK_LATENCY = 2,
    parameter int unsigned RING_TIMEOUT = 256
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] oneInp,
    input  logic [3:0] twoInp,
    output logic [3:0] onecurrent_state,
    output logic [3:0] twocurrent_state
);

    typedef enum logic [3:0] {
        StIdle      = 4'd0,
        StDialing   = 4'd1,
        StRingback  = 4'd2,
        StRinging   = 4'd3,
        StConnected = 4'd4,
        StBusy      = 4'd5
    } call_state_e;

    typedef enum logic [2:0] {
        MsgNone    = 3'd0,
        MsgInvite  = 3'd1,
        MsgRinging = 3'd2,
        MsgAccept  = 3'd3,
        MsgBye     = 3'd4,
        MsgDecline = 3'd5
    } msg_e;

    localparam logic [3:0] CmdDial   = 4'd1;
    localparam logic [3:0] CmdHangup = 4'd2;
    localparam logic [3:0] CmdAnswer = 4'd5;
    localparam logic [3:0] CmdReject = 4'd6;

    // Timer counts edges spent in DIALING/RINGBACK; it never exceeds RING_TIMEOUT-1.
    localparam int unsigned       TimerW    = $clog2(RING_TIMEOUT + 1);
    localparam logic [TimerW-1:0] TimerLast = TimerW'(RING_TIMEOUT - 1);

    // Registered state, with power-up values matching reset.
    call_state_e       state_q [2] = '{default: StIdle};
    logic [3:0]        prev_q  [2] = '{default: 4'd0};
    logic [TimerW-1:0] timer_q [2] = '{default: '0};
    // Per-direction message pipeline; stage LINK_LATENCY-1 is what the peer consumes.
    logic [1:0][LINK_LATENCY-1:0][2:0] link_q = '0;

    // Per-endpoint decode of the current cycle.
    logic [3:0] cmd_in    [2];
    logic [3:0] cmd       [2];
    logic       in_dr     [2];
    logic       timeout   [2];
    logic       hangup    [2];
    msg_e       rx        [2];
    msg_e       reply     [2];
    msg_e       local_msg [2];
    msg_e       send      [2];

    assign cmd_in[0] = oneInp;
    assign cmd_in[1] = twoInp;

    assign onecurrent_state = state_q[0];
    assign twocurrent_state = state_q[1];

    // Decode commands, arriving messages, timeouts and the one message each endpoint sends.
    always_comb begin
        cmd       = '{default: 4'd0};
        in_dr     = '{default: 1'b0};
        timeout   = '{default: 1'b0};
        hangup    = '{default: 1'b0};
        rx        = '{default: MsgNone};
        reply     = '{default: MsgNone};
        local_msg = '{default: MsgNone};
        send      = '{default: MsgNone};
        for (int e = 0; e < 2; e++) begin
            rx[e] = msg_e'(link_q[1-e][LINK_LATENCY-1]);

            // A held level acts once: only a nonzero change of the sampled code is a command.
            if (cmd_in[e] != 4'd0 && cmd_in[e] != prev_q[e]) begin
                cmd[e] = cmd_in[e];
            end

            in_dr[e]   = (state_q[e] == StDialing) || (state_q[e] == StRingback);
            timeout[e] = in_dr[e] && (timer_q[e] == TimerLast);
            // Timeout behaves exactly like a local hangup and outranks everything else.
            hangup[e]  = timeout[e] || (cmd[e] == CmdHangup && state_q[e] != StIdle);

            if (rx[e] == MsgInvite) begin
                reply[e] = (state_q[e] == StIdle) ? MsgRinging : MsgDecline;
            end

            if (hangup[e]) begin
                if (state_q[e] != StBusy) begin
                    local_msg[e] = MsgBye;
                end
            end else if (rx[e] == MsgNone) begin
                // Any arriving message discards a non-hangup command this cycle.
                case (cmd[e])
                    CmdDial: begin
                        if (state_q[e] == StIdle) local_msg[e] = MsgInvite;
                    end
                    CmdAnswer: begin
                        if (state_q[e] == StRinging) local_msg[e] = MsgAccept;
                    end
                    CmdReject: begin
                        if (state_q[e] == StRinging) local_msg[e] = MsgDecline;
                    end
                    default: ;
                endcase
            end

            // Only a local BYE can coincide with a reply; the BYE wins.
            send[e] = (local_msg[e] != MsgNone) ? local_msg[e] : reply[e];
        end
    end

    // Call-state FSM per endpoint, plus command edge detect and ring timer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int e = 0; e < 2; e++) begin
                state_q[e] <= StIdle;
                prev_q[e]  <= 4'd0;
                timer_q[e] <= '0;
            end
        end else begin
            for (int e = 0; e < 2; e++) begin
                prev_q[e]  <= cmd_in[e];
                timer_q[e] <= (in_dr[e] && !timeout[e]) ? timer_q[e] + TimerW'(1) : '0;

                if (hangup[e]) begin
                    state_q[e] <= StIdle;
                end else if (rx[e] != MsgNone) begin
                    case (rx[e])
                        MsgInvite: begin
                            if (state_q[e] == StIdle) state_q[e] <= StRinging;
                        end
                        MsgRinging: begin
                            if (state_q[e] == StDialing) state_q[e] <= StRingback;
                        end
                        MsgAccept: begin
                            if (in_dr[e]) state_q[e] <= StConnected;
                        end
                        MsgDecline: begin
                            if (in_dr[e]) state_q[e] <= StBusy;
                        end
                        MsgBye: begin
                            if (in_dr[e] || state_q[e] == StRinging ||
                                state_q[e] == StConnected) begin
                                state_q[e] <= StIdle;
                            end
                        end
                        default: ;
                    endcase
                end else begin
                    case (cmd[e])
                        CmdDial: begin
                            if (state_q[e] == StIdle) state_q[e] <= StDialing;
                        end
                        CmdAnswer: begin
                            if (state_q[e] == StRinging) state_q[e] <= StConnected;
                        end
                        CmdReject: begin
                            if (state_q[e] == StRinging) state_q[e] <= StIdle;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // Shift each direction's message pipeline; reset flushes anything in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            link_q <= '0;
        end else begin
            for (int e = 0; e < 2; e++) begin
                link_q[e][0] <= send[e];
                for (int s = 1; s < int'(LINK_LATENCY); s++) begin
                    link_q[e][s] <= link_q[e][s-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_complete.sv
`timescale 1ns / 1ps
// tb_complete: scoreboard bench for the two-endpoint call top. A message-queue reference model
// predicts both call states each cycle; a monitor compares them at the falling edge.

module tb_complete;

    localparam int unsigned LAT = 2;
    localparam int unsigned RT  = 256;

    // Model message codes.
    localparam int MNONE = 0;
    localparam int MINV  = 1;
    localparam int MRING = 2;
    localparam int MACC  = 3;
    localparam int MBYE  = 4;
    localparam int MDEC  = 5;

    logic       clk     = 1'b0;
    logic       reset   = 1'b0;
    logic [3:0] one_inp = 4'd0;
    logic [3:0] two_inp = 4'd0;
    logic [3:0] one_state;
    logic [3:0] two_state;

    complete #(
        .LINK_LATENCY(LAT),
        .RING_TIMEOUT(RT)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .oneInp          (one_inp),
        .twoInp          (two_inp),
        .onecurrent_state(one_state),
        .twocurrent_state(two_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        int dst;
        int msg;
    } flight_t;

    typedef struct {
        int    one;
        int    two;
        string tag;
    } exp_t;

    flight_t flight [$];
    exp_t    exp_q  [$];
    int      m_state [2];
    int      m_prev  [2];
    int      m_since [2];
    int      edge_no = 0;
    int      checks  = 0;
    int      passed  = 0;
    string   phase   = "powerup";

    // State reached when a message arrives with no local hangup.
    function automatic int on_message(input int s, input int msg);
        case (msg)
            MINV:    return (s == 0) ? 3 : s;
            MRING:   return (s == 1) ? 2 : s;
            MACC:    return (s == 1 || s == 2) ? 4 : s;
            MDEC:    return (s == 1 || s == 2) ? 5 : s;
            MBYE:    return (s >= 1 && s <= 4) ? 0 : s;
            default: return s;
        endcase
    endfunction

    // Advance the reference model by one rising edge.
    task automatic model_edge(input int a, input int b, input bit rst);
        int      inp [2];
        int      rx  [2];
        int      nxt [2];
        int      snd [2];
        flight_t f;
        inp[0] = a;
        inp[1] = b;
        if (rst) begin
            for (int e = 0; e < 2; e++) begin
                m_state[e] = 0;
                m_prev[e]  = 0;
                m_since[e] = 0;
            end
            flight.delete();
        end else begin
            rx[0] = MNONE;
            rx[1] = MNONE;
            for (int i = flight.size() - 1; i >= 0; i--) begin
                if (flight[i].due == edge_no) begin
                    rx[flight[i].dst] = flight[i].msg;
                    flight.delete(i);
                end
            end
            for (int e = 0; e < 2; e++) begin
                int s;
                int cmd;
                int loc;
                int rep;
                bit dr;
                bit hang;
                s   = m_state[e];
                cmd = (inp[e] != 0 && inp[e] != m_prev[e]) ? inp[e] : 0;
                m_prev[e] = inp[e];
                dr   = (s == 1 || s == 2);
                hang = (dr && (edge_no - m_since[e]) >= int'(RT)) || (cmd == 2 && s != 0);
                loc  = MNONE;
                rep  = MNONE;
                if (rx[e] == MINV) rep = (s == 0) ? MRING : MDEC;
                if (hang) begin
                    nxt[e] = 0;
                    if (s != 5) loc = MBYE;
                end else if (rx[e] != MNONE) begin
                    nxt[e] = on_message(s, rx[e]);
                end else begin
                    nxt[e] = s;
                    if (cmd == 1 && s == 0) begin
                        nxt[e] = 1;
                        loc    = MINV;
                    end else if (cmd == 5 && s == 3) begin
                        nxt[e] = 4;
                        loc    = MACC;
                    end else if (cmd == 6 && s == 3) begin
                        nxt[e] = 0;
                        loc    = MDEC;
                    end
                end
                snd[e] = (loc != MNONE) ? loc : rep;
                if ((nxt[e] == 1 || nxt[e] == 2) && !dr) m_since[e] = edge_no;
            end
            for (int e = 0; e < 2; e++) begin
                m_state[e] = nxt[e];
                if (snd[e] != MNONE) begin
                    f.due = edge_no + int'(LAT);
                    f.dst = 1 - e;
                    f.msg = snd[e];
                    flight.push_back(f);
                end
            end
        end
        edge_no++;
    endtask

    // Drive one cycle of stimulus and queue the predicted outputs after the next rising edge.
    task automatic step(input logic [3:0] a, input logic [3:0] b, input bit rst);
        exp_t x;
        @(negedge clk);
        #1;
        one_inp = a;
        two_inp = b;
        reset   = rst;
        model_edge(int'(a), int'(b), rst);
        x.one = m_state[0];
        x.two = m_state[1];
        x.tag = phase;
        exp_q.push_back(x);
    endtask

    task automatic check_val(input string name, input logic [3:0] got, input int want);
        checks++;
        if (got === 4'(want)) passed++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
    endtask

    function automatic logic [3:0] pick_cmd();
        int r;
        r = $urandom_range(9);
        case (r)
            0, 1:    return 4'd0;
            2, 3:    return 4'd1;
            4, 8:    return 4'd2;
            5, 6:    return 4'd5;
            7:       return 4'd6;
            default: return 4'($urandom_range(15));
        endcase
    endfunction

    // Monitor: compare queued predictions away from the active edge.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                check_val({x.tag, "/one"}, one_state, x.one);
                check_val({x.tag, "/two"}, two_state, x.two);
            end
        end
    end

    initial begin
        logic [3:0] ra;
        logic [3:0] rb;
        int         waited;
        for (int e = 0; e < 2; e++) begin
            m_state[e] = 0;
            m_prev[e]  = 0;
            m_since[e] = 0;
        end

        phase = "powerup";
        step(4'd0, 4'd0, 1'b0);
        step(4'd0, 4'd0, 1'b0);

        phase = "reset";
        step(4'd0, 4'd0, 1'b1);
        step(4'd0, 4'd0, 1'b1);
        step(4'd0, 4'd0, 1'b0);

        phase = "basic";
        step(4'd1, 4'd0, 1'b0);
        repeat (6) step(4'd1, 4'd0, 1'b0);
        step(4'd1, 4'd5, 1'b0);
        repeat (4) step(4'd1, 4'd5, 1'b0);

        phase = "held_dial";
        step(4'd1, 4'd2, 1'b0);
        repeat (6) step(4'd1, 4'd2, 1'b0);
        repeat (2) step(4'd0, 4'd0, 1'b0);

        phase = "reject";
        step(4'd1, 4'd0, 1'b0);
        repeat (5) step(4'd0, 4'd0, 1'b0);
        step(4'd0, 4'd6, 1'b0);
        repeat (4) step(4'd0, 4'd6, 1'b0);
        step(4'd2, 4'd6, 1'b0);
        repeat (3) step(4'd2, 4'd0, 1'b0);
        step(4'd0, 4'd0, 1'b0);

        phase = "timeout";
        step(4'd1, 4'd0, 1'b0);
        repeat (RT + 6) step(4'd1, 4'd0, 1'b0);
        step(4'd0, 4'd0, 1'b0);

        phase = "glare";
        step(4'd1, 4'd1, 1'b0);
        repeat (6) step(4'd1, 4'd1, 1'b0);
        repeat (3) step(4'd2, 4'd2, 1'b0);
        repeat (2) step(4'd0, 4'd0, 1'b0);

        phase = "teardown";
        step(4'd1, 4'd0, 1'b0);
        repeat (5) step(4'd0, 4'd0, 1'b0);
        step(4'd0, 4'd5, 1'b0);
        repeat (3) step(4'd0, 4'd0, 1'b0);
        step(4'd2, 4'd0, 1'b0);
        repeat (4) step(4'd0, 4'd0, 1'b0);

        phase = "reset_mid";
        step(4'd1, 4'd0, 1'b0);
        repeat (5) step(4'd0, 4'd0, 1'b0);
        step(4'd0, 4'd5, 1'b0);
        repeat (3) step(4'd0, 4'd0, 1'b0);
        step(4'd0, 4'd0, 1'b1);
        step(4'd0, 4'd0, 1'b0);
        step(4'd1, 4'd0, 1'b0);
        step(4'd0, 4'd0, 1'b1);
        step(4'd0, 4'd0, 1'b0);
        repeat (6) step(4'd0, 4'd0, 1'b0);

        phase = "random";
        ra = 4'd0;
        rb = 4'd0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(3) == 0) ra = pick_cmd();
            if ($urandom_range(3) == 0) rb = pick_cmd();
            step(ra, rb, $urandom_range(299) == 0);
        end

        phase = "drain";
        step(4'd0, 4'd0, 1'b0);
        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
